// File: rtl/seg_serial_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_serial_capture
// Brief    : Receiver for the serial 7-segment link; rebuilds 64-bit frames
//            and decodes each digit byte to a hex nibble plus decimal point.
// Revision : 1.0 - initial release
// ============================================================================
module seg_serial_capture #(
    parameter int FRAME_BITS  = 64,
    parameter int DIGITS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ser_clk,
    input  logic                    ser_clrn,
    input  logic                    ser_out,
    input  logic                    ser_en,
    output logic [FRAME_BITS-1:0]   frame_raw,
    output logic [4*DIGITS-1:0]     hexs,
    output logic [DIGITS-1:0]       points,
    output logic [DIGITS-1:0]       digit_ok,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam int c_CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FRAME_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_OVF  = c_CNT_W'(FRAME_BITS + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    // Bit order of the synchroniser vector: {en, out, clrn, clk}
    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic [3:0]                  w_sync;
    logic [3:0]                  r_sync_d;
    logic                        r_clk_edge;
    logic                        r_en_edge;
    logic                        w_clrn;
    logic                        w_bit;

    assign w_sync = r_sync[SYNC_STAGES-1];
    // Delayed copies line up with the registered edge strobes
    assign w_clrn = r_sync_d[1];
    assign w_bit  = r_sync_d[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync     <= '0;
            r_sync_d   <= '0;
            r_clk_edge <= 1'b0;
            r_en_edge  <= 1'b0;
        end else begin
            r_sync[0] <= {ser_en, ser_out, ser_clrn, ser_clk};
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_sync_d   <= w_sync;
            r_clk_edge <= w_sync[0] & ~r_sync_d[0];
            r_en_edge  <= w_sync[3] & ~r_sync_d[3];
        end
    end

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [FRAME_BITS-1:0]  w_shift_nxt;
    logic                   w_latch_ok;
    logic                   w_latch_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // A shift in the same cycle as a latch strobe is applied before the count is judged
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_latch_ok  = 1'b0;
        w_latch_bad = 1'b0;
        if (!w_clrn) begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
        end else begin
            if (r_clk_edge) begin
                w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_bit};
                if (r_cnt != c_CNT_OVF) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                case (r_state)
                    c_IDLE:  w_state_nxt = (w_cnt_nxt == c_CNT_FULL) ? c_FULL : c_SHIFT;
                    c_SHIFT: w_state_nxt = (w_cnt_nxt == c_CNT_FULL) ? c_FULL : c_SHIFT;
                    c_FULL:  w_state_nxt = c_SHIFT;
                    default: w_state_nxt = c_IDLE;
                endcase
            end
            if (r_en_edge) begin
                w_latch_ok  = (w_cnt_nxt == c_CNT_FULL);
                w_latch_bad = (w_cnt_nxt != c_CNT_FULL);
                w_cnt_nxt   = '0;
                w_state_nxt = c_IDLE;
            end
        end
    end

    // Returns {legal, nibble}; segment bits are active-low {g,f,e,d,c,b,a}
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h40:   return 5'h10;
            7'h79:   return 5'h11;
            7'h24:   return 5'h12;
            7'h30:   return 5'h13;
            7'h19:   return 5'h14;
            7'h12:   return 5'h15;
            7'h02:   return 5'h16;
            7'h78:   return 5'h17;
            7'h00:   return 5'h18;
            7'h10:   return 5'h19;
            7'h08:   return 5'h1A;
            7'h03:   return 5'h1B;
            7'h46:   return 5'h1C;
            7'h21:   return 5'h1D;
            7'h06:   return 5'h1E;
            7'h0E:   return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    logic [4*DIGITS-1:0] w_hex;
    logic [DIGITS-1:0]   w_pts;
    logic [DIGITS-1:0]   w_ok;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_dec
            logic [4:0] w_dec;
            assign w_dec          = seg_decode(w_shift_nxt[8*i +: 7]);
            assign w_hex[4*i +: 4] = w_dec[3:0];
            assign w_ok[i]         = w_dec[4];
            assign w_pts[i]        = ~w_shift_nxt[8*i + 7];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_raw   <= '1;
            hexs        <= '0;
            points      <= '0;
            digit_ok    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= w_latch_ok;
            frame_err   <= w_latch_bad;
            if (w_latch_ok) begin
                frame_raw <= w_shift_nxt;
                hexs      <= w_hex;
                points    <= w_pts;
                digit_ok  <= w_ok;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_serial_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_serial_capture
// Brief    : Directed self-checking bench for seg_serial_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_serial_capture;

    logic        clk;
    logic        rst;
    logic        ser_clk;
    logic        ser_clrn;
    logic        ser_out;
    logic        ser_en;
    logic [63:0] frame_raw;
    logic [31:0] hexs;
    logic [7:0]  points;
    logic [7:0]  digit_ok;
    logic        frame_valid;
    logic        frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    seg_serial_capture #(
        .FRAME_BITS  (64),
        .DIGITS      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ser_clk     (ser_clk),
        .ser_clrn    (ser_clrn),
        .ser_out     (ser_out),
        .ser_en      (ser_en),
        .frame_raw   (frame_raw),
        .hexs        (hexs),
        .points      (points),
        .digit_ok    (digit_ok),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ser_out = b;
        ser_clk = 1'b0;
        repeat (4) @(negedge clk);
        ser_clk = 1'b1;
        repeat (4) @(negedge clk);
        ser_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(f[63 - (i % 64)]);
        end
    endtask

    // Pulses appear only on the 3rd edge after the one that samples ser_en
    task automatic pulse_en(input string tag, input logic exp_v, input logic exp_e);
        @(negedge clk);
        ser_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "_valid"}, {63'd0, frame_valid}, {63'd0, (k == 3) ? exp_v : 1'b0});
            chk({tag, "_err"},   {63'd0, frame_err},   {63'd0, (k == 3) ? exp_e : 1'b0});
        end
        @(posedge clk);
        #1;
        chk({tag, "_pulse_end"}, {62'd0, frame_valid, frame_err}, 64'd0);
        repeat (4) @(negedge clk);
        ser_en = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input logic [63:0] raw, input logic [31:0] hx,
                            input logic [7:0] pt, input logic [7:0] ok);
        chk({tag, "_raw"},  frame_raw, raw);
        chk({tag, "_hexs"}, {32'd0, hexs}, {32'd0, hx});
        chk({tag, "_pts"},  {56'd0, points}, {56'd0, pt});
        chk({tag, "_ok"},   {56'd0, digit_ok}, {56'd0, ok});
    endtask

    localparam logic [63:0] c_F12345678 = 64'hF9A4_B099_9282_F880;
    localparam logic [63:0] c_FDEADBEEF = 64'hA186_88A1_8386_868E;
    localparam logic [63:0] c_FILLEGAL  = 64'h9080_F882_9299_40FF;

    initial begin
        rst      = 1'b1;
        ser_clk  = 1'b0;
        ser_clrn = 1'b1;
        ser_out  = 1'b0;
        ser_en   = 1'b0;
        repeat (3) @(negedge clk);
        chk_outs("reset", 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 8'h00, 8'h00);
        chk("reset_pulses", {62'd0, frame_valid, frame_err}, 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send_bits(c_F12345678, 64);
        pulse_en("good", 1'b1, 1'b0);
        chk_outs("good", c_F12345678, 32'h1234_5678, 8'h00, 8'hFF);

        send_bits(c_FDEADBEEF, 40);
        pulse_en("short", 1'b0, 1'b1);
        chk_outs("short", c_F12345678, 32'h1234_5678, 8'h00, 8'hFF);

        send_bits(c_FDEADBEEF, 65);
        pulse_en("ovf", 1'b0, 1'b1);
        chk_outs("ovf", c_F12345678, 32'h1234_5678, 8'h00, 8'hFF);

        send_bits(c_F12345678, 30);
        @(negedge clk);
        ser_clrn = 1'b0;
        repeat (6) @(negedge clk);
        ser_clrn = 1'b1;
        repeat (6) @(negedge clk);
        send_bits(c_FDEADBEEF, 64);
        pulse_en("clear", 1'b1, 1'b0);
        chk_outs("clear", c_FDEADBEEF, 32'hDEAD_BEEF, 8'h00, 8'hFF);

        send_bits(c_FILLEGAL, 64);
        pulse_en("illegal", 1'b1, 1'b0);
        chk_outs("illegal", c_FILLEGAL, 32'h9876_5400, 8'h02, 8'hFE);

        send_bits(c_FDEADBEEF, 20);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outs("midrst", 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_bits(c_F12345678, 64);
        pulse_en("after_rst", 1'b1, 1'b0);
        chk_outs("after_rst", c_F12345678, 32'h1234_5678, 8'h00, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_serial_capture.md
Name: seg_serial_capture

Overview:
- Board-side receiver for the serial 7-segment link driven by the display driver (sclk/sclrn/sout/EN).
- Deserialises each 64-bit frame (8 digits x 8 segment bits) in the clk domain.
- Decodes every digit byte back to a hex nibble and a decimal-point flag.
- Used in simulation and on-chip self-check to confirm that the displayed value equals the intended 32-bit score.

Parameters:
- FRAME_BITS, 64: bits per frame; must be 8 x DIGITS.
- DIGITS, 8: number of digits per frame.
- SYNC_STAGES, 2: synchroniser depth on every serial input.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- ser_clk  in  1  serial shift clock; asynchronous to clk
- ser_clrn  in  1  serial clear, active-low
- ser_out  in  1  serial data
- ser_en  in  1  latch enable; rising edge ends a frame
- frame_raw  out  64  last accepted frame, bit 63 = first bit received
- hexs  out  32  decoded digits; nibble i from byte i of frame_raw
- points  out  8  decimal point per digit, 1 = lit
- digit_ok  out  8  1 = byte i matched a legal hex pattern
- frame_valid  out  1  one-cycle pulse when a good frame is accepted
- frame_err  out  1  one-cycle pulse when a frame is rejected

Interface: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Reset values:
  - frame_raw = 64'hFFFF_FFFF_FFFF_FFFF (blank display)
  - hexs = 0, points = 0, digit_ok = 0
  - frame_valid = 0, frame_err = 0
  - shift register = 0, bit counter = 0, state = IDLE
- Synchronisation:
  - ser_clk, ser_clrn, ser_out and ser_en each pass through SYNC_STAGES flops.
  - Edges are detected against a further registered copy.
  - Each ser_clk and ser_en level must hold for at least SYNC_STAGES+1 clk cycles.
- Shifting:
  - On a detected ser_clk rising edge: shift_reg <= {shift_reg[62:0], ser_out_sync}.
  - The counter increments and saturates at FRAME_BITS+1. Saturation marks overflow.
- Clear:
  - While ser_clrn_sync = 0: shift register and counter are held at 0 and state = IDLE.
  - Clear overrides a simultaneous ser_clk edge.
  - Outputs are not touched.
- States:
  - IDLE -> SHIFT on the first ser_clk edge.
  - SHIFT -> FULL when count reaches FRAME_BITS.
  - FULL -> SHIFT (overflow flagged) on a further ser_clk edge.
  - Any state -> IDLE on clear or on a ser_en rising edge.
- Latch, on a detected ser_en rising edge:
  - count == FRAME_BITS exactly: load frame_raw from the shift register, update hexs, points and digit_ok, pulse frame_valid.
  - Otherwise (short or overflowed frame): pulse frame_err and leave all outputs unchanged.
  - In both cases the counter is reset to 0.
- Simultaneous ser_en edge and ser_clk edge in the same cycle: the shift is applied first, and the latch then evaluates the updated count.
- Latency: frame_valid/frame_err and the updated outputs appear on the 3rd clk rising edge after the first edge that samples ser_en = 1 (with SYNC_STAGES = 2). All outputs are registered.
- Decode, byte i = frame_raw[8i+7:8i], active-low, bit order {dp,g,f,e,d,c,b,a}:
  - Segment patterns, 0-9: C0 F9 A4 B0 99 92 82 F8 80 90.
  - Segment patterns, A-F: 88 83 C6 A1 86 8E.
  - Matching ignores bit 7. points[i] = ~byte[7].
  - If the segment bits match no entry: nibble = 0 and digit_ok[i] = 0.
- rst asserted mid-frame: everything returns to reset values immediately. A partial frame is discarded silently, with no err pulse.

Test Plan:
- Reset check: assert rst -> frame_raw = all-F, hexs = 0, points = 0, digit_ok = 0, no pulses.
- Good frame: shift 64 bits encoding 0x12345678 with dp off (bytes F9 A4 B0 99 92 82 F8 80, digit 7 first), then pulse ser_en -> hexs = 32'h12345678, points = 0, digit_ok = FF, single frame_valid pulse exactly 3 clk after ser_en is sampled.
- Short frame: 40 bits then ser_en -> frame_err pulse, outputs keep their previous values. Overflow frame of 65 bits then ser_en -> frame_err pulse, outputs unchanged.
- Clear mid-frame: 30 bits, ser_clrn low, then a full 0xDEADBEEF frame -> hexs = DEADBEEF, frame_valid pulse.
- Illegal and dp bytes: byte 0 = FF and byte 1 = 40 (dp lit, "0") -> digit_ok[0] = 0, hexs[3:0] = 0, points[1] = 1, digit_ok[1] = 1.
- Reset during shifting: rst after 20 bits, then a full frame -> accepted normally, no frame_err pulse.
